// File: rtl/lc3_io_pkg.sv
// Shared LC-3 memory-mapped I/O definitions: register addresses, DSR bit positions, transmitter states.
// No logic; latency and backpressure not applicable.
package lc3_io_pkg;

    localparam logic [15:0] DDR_ADDR = 16'hFE06;
    localparam logic [15:0] DSR_ADDR = 16'hFE04;

    localparam int DSR_READY   = 15;
    localparam int DSR_OVERRUN = 14;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/lc3_display_tx_if.sv
// DDR store strobe/data toward the display transmitter, DSR/serial status back.
// Pure wiring, zero latency; the CPU side must poll dsr ready before storing.
interface lc3_display_tx_if;
    logic        ddr_wr;
    logic [15:0] ddr_data;
    logic [15:0] dsr;
    logic        tx;
    logic        busy;

    modport master (
        output ddr_wr,
        output ddr_data,
        input  dsr,
        input  tx,
        input  busy
    );

    modport slave (
        input  ddr_wr,
        input  ddr_data,
        output dsr,
        output tx,
        output busy
    );
endinterface

// File: rtl/baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses tick on the last count.
// tick is combinational from the count register; clear restarts the period on the next cycle.
module baud_counter #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);
    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/lc3_display_tx.sv
// LC-3 display transmitter: a DDR store is sent as an async 8N1 frame (8E1 with LC3_DISPLAY_PARITY_EN).
// tx goes low the cycle after the store; ready returns 10N+1 cycles later (11N+1 with parity).
// Stores while busy are dropped and flagged in the DSR overrun bit; no stall is applied.
module lc3_display_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    lc3_display_tx_if.slave      bus
);
    import lc3_io_pkg::*;

    localparam logic [2:0] ST_IDLE   = TX_IDLE;
    localparam logic [2:0] ST_START  = TX_START;
    localparam logic [2:0] ST_DATA   = TX_DATA;
    localparam logic [2:0] ST_PARITY = TX_PARITY;
    localparam logic [2:0] ST_STOP   = TX_STOP;

    logic [2:0] state;
    logic [7:0] shreg;
    logic [2:0] bit_cnt;
    logic       tx_q;
    logic       ovr_q;
    logic       tick;
    logic       accept;
`ifdef LC3_DISPLAY_PARITY_EN
    logic       par_q;
`endif

    // Upper store byte is architecturally ignored.
    logic unused_hi;
    assign unused_hi = ^bus.ddr_data[15:8];

    assign accept = bus.ddr_wr && (state == ST_IDLE);

    baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clock (clock),
        .reset (reset),
        .clear (accept),
        .tick  (tick)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            tx_q    <= 1'b1;
            ovr_q   <= 1'b0;
`ifdef LC3_DISPLAY_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            if (bus.ddr_wr) begin
                ovr_q <= !accept;
            end

            case (state)
                ST_IDLE: begin
                    if (bus.ddr_wr) begin
                        shreg   <= bus.ddr_data[7:0];
                        bit_cnt <= '0;
                        tx_q    <= 1'b0;
                        state   <= ST_START;
`ifdef LC3_DISPLAY_PARITY_EN
                        par_q   <= ^bus.ddr_data[7:0];
`endif
                    end
                end
                ST_START: begin
                    if (tick) begin
                        tx_q  <= shreg[0];
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bit_cnt == 3'd7) begin
`ifdef LC3_DISPLAY_PARITY_EN
                            tx_q  <= par_q;
                            state <= ST_PARITY;
`else
                            tx_q  <= 1'b1;
                            state <= ST_STOP;
`endif
                        end else begin
                            // Next bit is pre-shifted into [1] so tx stays a plain register.
                            tx_q    <= shreg[1];
                            shreg   <= {1'b0, shreg[7:1]};
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        tx_q  <= 1'b1;
                        state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    tx_q  <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bus.dsr              = '0;
        bus.dsr[DSR_READY]   = (state == ST_IDLE);
        bus.dsr[DSR_OVERRUN] = ovr_q;
    end

    assign bus.tx   = tx_q;
    assign bus.busy = (state != ST_IDLE);
endmodule

// File: doc/lc3_display_tx.md
# lc3_display_tx

Display output transmitter for the LC-3 memory-mapped I/O block, on the read side of the Display Data Register (DDR, xFE06). A CPU store to DDR loads one character. The block clears the DSR ready bit, sends the low byte LSB-first as an asynchronous 8N1 serial frame, then sets ready again so polling software can issue the next character.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit (N). Must be ≥ 2.
- `clock`  in  1  system clock; all state changes on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `ddr_wr`  in  1  one-cycle strobe: CPU store to DDR
- `ddr_data`  in  16  store data; only [7:0] are used
- `dsr`  out  16  Display Status Register value: [15] ready, [14] overrun, [13:0] zero
- `tx`  out  1  serial line; idles high
- `busy`  out  1  high while a frame is in progress (equals ~dsr[15])

## Operation
- Reset values: `tx`=1, `dsr`=16'h8000, `busy`=0, state IDLE, baud and bit counters 0.
- States: IDLE → START → DATA → [PARITY] → STOP → IDLE.
- IDLE: when `ddr_wr`=1, latch ddr_data[7:0] into the shift register, clear overrun, and go to START.
- START: `tx`=0 for N cycles.
- DATA: 8 bits sent LSB first, each held N cycles. A 3-bit counter tracks the bit; after bit 7 the state advances.
- STOP: `tx`=1 for N cycles, then IDLE with dsr[15]=1.
- Write while busy: the data is dropped, dsr[14] is set and stays set until the next accepted write, and the frame in progress is unaffected.
- `ddr_wr` in the same cycle as `reset`: ignored.
- Reset mid-frame: the frame is aborted and the next cycle shows the reset values (`tx`=1 immediately).
- ddr_data[15:8] have no effect.

## Timing
- `ddr_wr` accepted at cycle T. From T+1: `tx`=0, dsr[15]=0, `busy`=1.
- Data bit i is driven during cycles T+1+N(1+i) through T+N(2+i).
- Stop bit is driven during cycles T+1+9N through T+10N.
- dsr[15]=1 from T+10N+1. A `ddr_wr` in that same cycle is accepted, so back-to-back frames have no idle gap.
- Frame length is 10N cycles, or 11N cycles with parity.
- The baud counter counts 0..N-1 and wraps. A bit or state advance happens only on the wrap.
- `tx` is a registered output: no combinational path from inputs to `tx`.

## Configuration
- `LC3_DISPLAY_PARITY_EN` defined: a PARITY state sits between DATA and STOP. It sends one even-parity bit (XOR of the 8 data bits) for N cycles. Frame is 11N cycles; ready returns at T+11N+1.
- Undefined: no PARITY state, 8N1 framing, 10N-cycle frame.

## Structure
- Shared package `lc3_io_pkg` holds:
  - constants `DDR_ADDR`=16'hFE06 and `DSR_ADDR`=16'hFE04
  - DSR bit indices `DSR_READY`=15 and `DSR_OVERRUN`=14
  - the transmitter state enum
- One sub-module, `baud_counter`:
  - parameterised by `CLKS_PER_BIT`
  - inputs `clock`, `reset`, `clear`; output `tick` (one cycle at wrap)
  - `clear` is asserted on frame acceptance.

## Test plan
All scenarios use N=4 and parity disabled unless stated.
- Write 16'h0041 ('A') → `tx` shows 0,1,0,0,0,0,0,1,0,1, each bit for 4 cycles. `dsr`=16'h0000 from T+1 to T+40; 16'h8000 at T+41.
- Write 16'hFF41 → waveform identical to 16'h0041.
- Write 16'h0041, then write 16'h0042 at T+10 → waveform still 'A'; `dsr`=16'h4000 during the frame; 16'hC000 at T+41. A following write of 16'h0042 is accepted and `dsr` returns to 16'h0000.
- Back-to-back: write 'A' at T, write 'B' (16'h0042) at T+41 → 'B' start bit begins at T+42; no extra high cycles between frames.
- Assert `reset` at T+15 → at T+16: `tx`=1, `dsr`=16'h8000, `busy`=0. A write at T+17 starts a clean frame.
- Parity build: 'A' (16'h0041) → parity bit 0. 'C' (16'h0043) → parity bit 1. Frame is 44 cycles; ready returns at T+45.
